usb_word_bridge: RTL and testbench

- Parametrised byte/word bridge between the USB byte-stream side and the word-wide stock/average data path.
- RX path assembles incoming USB payload bytes into WORD_BYTES-wide words, with packet-start resynchronisation.
- TX path serialises a loaded word into bytes under a valid/ready handshake.
- Sits between the USB receiver/transmitter byte interfaces and the stock processing core; generalises the fixed 32-bit operation controller in width, byte order and framing.

---
 rtl/usb_pkg.sv | 21 ++
 rtl/usb_tx_serializer.sv | 87 ++++++++
 rtl/usb_word_bridge.sv | 96 +++++++++
 tb/tb_usb_word_bridge.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared definitions for the USB byte/word bridge: byte width, TX FSM states
// and the byte-slot mapping used for wire byte order.
package usb_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    // Word slot that the idx-th byte on the wire occupies.
    function automatic int unsigned byte_slot(
        input int unsigned idx,
        input int unsigned n_bytes,
        input bit          lsb_first
    );
        return lsb_first ? idx : (n_bytes - 1 - idx);
    endfunction

endpackage

// File: rtl/usb_tx_serializer.sv
// Word-to-byte serialiser: captures one word on load and emits it byte by byte
// under a valid/ready handshake, pulsing tx_done after the final byte.
module usb_tx_serializer
    import usb_pkg::*;
#(
    parameter int WORD_BYTES = 4,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic [8*WORD_BYTES-1:0]      tx_word,
    input  logic                         tx_word_load,
    output logic                         tx_busy,
    output logic [BYTE_W-1:0]            tx_byte,
    output logic                         tx_byte_valid,
    input  logic                         tx_byte_ready,
    output logic                         tx_done
);

    localparam int W  = 8 * WORD_BYTES;
    localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORD_BYTES - 1);

    tx_state_t       r_state;
    logic [W-1:0]    r_shift;
    logic [IW-1:0]   r_idx;
    logic            r_busy;
    logic            r_valid;
    logic            r_done;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= TX_IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                TX_IDLE: begin
                    if (tx_word_load) begin
                        r_shift <= tx_word;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b1;
                        r_state <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    // Shifting in zeros leaves tx_byte at 0 once the word is drained.
                    if (tx_byte_ready) begin
                        r_shift <= LSB_FIRST ? (r_shift >> BYTE_W) : (r_shift << BYTE_W);
                        if (r_idx == LAST_IDX) begin
                            r_idx   <= '0;
                            r_busy  <= 1'b0;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= TX_IDLE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_state <= TX_IDLE;
                end
            endcase
        end
    end

    generate
        if (LSB_FIRST) begin : g_lsb_out
            assign tx_byte = r_shift[BYTE_W-1:0];
        end else begin : g_msb_out
            assign tx_byte = r_shift[W-1 -: BYTE_W];
        end
    endgenerate

    assign tx_busy       = r_busy;
    assign tx_byte_valid = r_valid;
    assign tx_done       = r_done;

endmodule

// File: rtl/usb_word_bridge.sv
// Byte/word bridge between the USB byte stream and the word-wide data path:
// inline RX word assembly with packet-start resync, TX via usb_tx_serializer.
module usb_word_bridge
    import usb_pkg::*;
#(
    parameter int WORD_BYTES = 4,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic [BYTE_W-1:0]            rx_byte,
    input  logic                         rx_byte_valid,
    input  logic                         rx_packet_start,
    output logic [8*WORD_BYTES-1:0]      rx_word,
    output logic                         rx_word_valid,
    output logic                         rx_error,
    input  logic [8*WORD_BYTES-1:0]      tx_word,
    input  logic                         tx_word_load,
    output logic                         tx_busy,
    output logic [BYTE_W-1:0]            tx_byte,
    output logic                         tx_byte_valid,
    input  logic                         tx_byte_ready,
    output logic                         tx_done
);

    localparam int W  = 8 * WORD_BYTES;
    localparam int CW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WORD_BYTES - 1);

    logic [CW-1:0] r_rx_cnt;
    logic [W-1:0]  r_rx_asm;
    logic [W-1:0]  r_rx_word;
    logic          r_rx_word_valid;
    logic          r_rx_error;

    logic [CW-1:0] w_cnt_eff;
    logic [CW-1:0] w_slot;
    logic [W-1:0]  w_asm_next;

    // A packet start rewinds the count before the same-cycle byte is placed.
    assign w_cnt_eff = rx_packet_start ? '0 : r_rx_cnt;
    assign w_slot    = CW'(byte_slot(32'(w_cnt_eff), WORD_BYTES, LSB_FIRST));

    generate
        for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_rx_slot
            assign w_asm_next[gi*BYTE_W +: BYTE_W] =
                (rx_byte_valid && (w_slot == CW'(gi))) ? rx_byte
                                                       : r_rx_asm[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rx_cnt        <= '0;
            r_rx_asm        <= '0;
            r_rx_word       <= '0;
            r_rx_word_valid <= 1'b0;
            r_rx_error      <= 1'b0;
        end else begin
            r_rx_word_valid <= 1'b0;
            r_rx_error      <= rx_packet_start && (r_rx_cnt != '0);
            if (rx_byte_valid) begin
                r_rx_asm <= w_asm_next;
                if (w_cnt_eff == LAST_CNT) begin
                    r_rx_word       <= w_asm_next;
                    r_rx_word_valid <= 1'b1;
                    r_rx_cnt        <= '0;
                end else begin
                    r_rx_cnt <= w_cnt_eff + 1'b1;
                end
            end else begin
                r_rx_cnt <= w_cnt_eff;
            end
        end
    end

    assign rx_word       = r_rx_word;
    assign rx_word_valid = r_rx_word_valid;
    assign rx_error      = r_rx_error;

    usb_tx_serializer #(
        .WORD_BYTES (WORD_BYTES),
        .LSB_FIRST  (LSB_FIRST)
    ) u_tx (
        .clk           (clk),
        .n_rst         (n_rst),
        .tx_word       (tx_word),
        .tx_word_load  (tx_word_load),
        .tx_busy       (tx_busy),
        .tx_byte       (tx_byte),
        .tx_byte_valid (tx_byte_valid),
        .tx_byte_ready (tx_byte_ready),
        .tx_done       (tx_done)
    );

endmodule

// File: tb/tb_usb_word_bridge.sv
// Bench for usb_word_bridge: one LSB-first and one MSB-first instance share
// stimulus; expected words/bytes go into scoreboards and are checked on output.
module tb_usb_word_bridge;

    localparam int WB = 4;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [7:0]  rx_byte = '0;
    logic        rx_byte_valid = 1'b0;
    logic        rx_packet_start = 1'b0;
    logic [31:0] tx_word = '0;
    logic        tx_word_load = 1'b0;
    logic        tx_byte_ready = 1'b0;

    logic [31:0] rx_word_a, rx_word_b;
    logic        rx_word_valid_a, rx_word_valid_b;
    logic        rx_error_a, rx_error_b;
    logic        tx_busy_a, tx_busy_b;
    logic [7:0]  tx_byte_a, tx_byte_b;
    logic        tx_byte_valid_a, tx_byte_valid_b;
    logic        tx_done_a, tx_done_b;

    always #5 clk = ~clk;

    usb_word_bridge #(.WORD_BYTES(WB), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .n_rst(n_rst),
        .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid), .rx_packet_start(rx_packet_start),
        .rx_word(rx_word_a), .rx_word_valid(rx_word_valid_a), .rx_error(rx_error_a),
        .tx_word(tx_word), .tx_word_load(tx_word_load), .tx_busy(tx_busy_a),
        .tx_byte(tx_byte_a), .tx_byte_valid(tx_byte_valid_a), .tx_byte_ready(tx_byte_ready),
        .tx_done(tx_done_a)
    );

    usb_word_bridge #(.WORD_BYTES(WB), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .n_rst(n_rst),
        .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid), .rx_packet_start(rx_packet_start),
        .rx_word(rx_word_b), .rx_word_valid(rx_word_valid_b), .rx_error(rx_error_b),
        .tx_word(tx_word), .tx_word_load(tx_word_load), .tx_busy(tx_busy_b),
        .tx_byte(tx_byte_b), .tx_byte_valid(tx_byte_valid_b), .tx_byte_ready(tx_byte_ready),
        .tx_done(tx_done_b)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int unsigned c;
    } rx_exp_t;

    typedef struct {
        logic [7:0]  b [6];
        logic [5:0]  v;
        logic [5:0]  ps;
        int          n;
        int          gap;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        int          exp_err;
    } rx_vec_t;

    rx_exp_t     rx_q [$];
    logic [7:0]  txq_a [$];
    logic [7:0]  txq_b [$];
    rx_exp_t     mon_e;
    rx_vec_t     vecs [6];
    int          n_err_a = 0;
    int          n_err_b = 0;
    int          n_done_seen = 0;
    int unsigned last_hs_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (n_rst) begin
            if (rx_word_valid_a || rx_word_valid_b) begin
                if (rx_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rx_unexpected_valid: got word %h/%h, expected no valid", rx_word_a, rx_word_b);
                end else begin
                    mon_e = rx_q.pop_front();
                    check("rx_word_lsb", 64'(rx_word_a), 64'(mon_e.a));
                    check("rx_word_msb", 64'(rx_word_b), 64'(mon_e.b));
                    check("rx_valid_latency", 64'(cyc), 64'(mon_e.c + 1));
                    check("rx_valid_both", 64'({rx_word_valid_a, rx_word_valid_b}), 64'(2'b11));
                    $display("[TB] rx word lsb=%h msb=%h at cycle %0d", rx_word_a, rx_word_b, cyc);
                end
            end
            if (rx_error_a) n_err_a++;
            if (rx_error_b) n_err_b++;
            if ((tx_byte_valid_a || tx_byte_valid_b) && tx_byte_ready) begin
                if (txq_a.size() == 0 || txq_b.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tx_unexpected_byte: got %h/%h, expected no handshake", tx_byte_a, tx_byte_b);
                end else begin
                    check("tx_byte_lsb", 64'(tx_byte_a), 64'(txq_a.pop_front()));
                    check("tx_byte_msb", 64'(tx_byte_b), 64'(txq_b.pop_front()));
                    last_hs_cyc = cyc;
                    $display("[TB] tx byte lsb=%h msb=%h at cycle %0d", tx_byte_a, tx_byte_b, cyc);
                end
            end
            if (tx_done_a) begin
                n_done_seen++;
                check("tx_done_latency", 64'(cyc), 64'(last_hs_cyc + 1));
                check("tx_done_msb", 64'(tx_done_b), 64'(1'b1));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_rx(input int k);
        int err_a0 = n_err_a;
        int err_b0 = n_err_b;
        for (int i = 0; i < vecs[k].n; i++) begin
            rx_byte         = vecs[k].b[i];
            rx_byte_valid   = vecs[k].v[i];
            rx_packet_start = vecs[k].ps[i];
            if (vecs[k].v[i] && i == vecs[k].n - 1)
                rx_q.push_back('{vecs[k].exp_a, vecs[k].exp_b, cyc});
            tick();
            rx_byte_valid   = 1'b0;
            rx_packet_start = 1'b0;
            for (int g = 0; g < vecs[k].gap; g++) tick();
        end
        repeat (3) tick();
        check("rx_missing_valid", 64'(rx_q.size()), 64'd0);
        rx_q.delete();
        check("rx_error_count_lsb", 64'(n_err_a - err_a0), 64'(vecs[k].exp_err));
        check("rx_error_count_msb", 64'(n_err_b - err_b0), 64'(vecs[k].exp_err));
        check("rx_word_hold", 64'(rx_word_a), 64'(vecs[k].exp_a));
    endtask

    task automatic push_tx(input logic [31:0] w);
        for (int i = 0; i < WB; i++) begin
            txq_a.push_back(w[8*i +: 8]);
            txq_b.push_back(w[8*(WB-1-i) +: 8]);
        end
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (!tx_done_a && t < 20) begin
            tick();
            t++;
        end
        check(name, 64'(tx_done_a), 64'(1'b1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_word"},  64'({rx_word_a, rx_word_b}), 64'd0);
        check({tag, "_rx_flags"}, 64'({rx_word_valid_a, rx_word_valid_b, rx_error_a, rx_error_b}), 64'd0);
        check({tag, "_tx_flags"}, 64'({tx_busy_a, tx_busy_b, tx_byte_valid_a, tx_byte_valid_b, tx_done_a, tx_done_b}), 64'd0);
        check({tag, "_tx_byte"},  64'({tx_byte_a, tx_byte_b}), 64'd0);
    endtask

    initial begin
        int done0;
        vecs[0] = '{'{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00}, 6'b001111, 6'b000000, 4, 0,
                    32'h44332211, 32'h11223344, 0};
        vecs[1] = '{'{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00}, 6'b001111, 6'b000000, 4, 3,
                    32'h44332211, 32'h11223344, 0};
        vecs[2] = '{'{8'hAA, 8'hBB, 8'h01, 8'h02, 8'h03, 8'h04}, 6'b111111, 6'b000100, 6, 0,
                    32'h04030201, 32'h01020304, 1};
        vecs[3] = '{'{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00}, 6'b001111, 6'b000001, 4, 0,
                    32'h04030201, 32'h01020304, 0};
        vecs[4] = '{'{8'hAA, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40}, 6'b111101, 6'b000010, 6, 0,
                    32'h40302010, 32'h10203040, 1};
        vecs[5] = '{'{8'h5A, 8'hA5, 8'hC3, 8'h3C, 8'h00, 8'h00}, 6'b001111, 6'b000000, 4, 1,
                    32'h3CC3A55A, 32'h5AA5C33C, 0};

        repeat (3) tick();
        check_all_zero("reset_held");
        n_rst = 1'b1;
        tick();
        check_all_zero("reset_out");

        for (int k = 0; k < 6; k++) begin
            $display("[TB] rx vector %0d", k);
            run_rx(k);
        end

        // TX: stall with ready low, then drain; a mid-send load must be ignored.
        tx_word = 32'hDEADBEEF;
        tx_word_load = 1'b1;
        push_tx(32'hDEADBEEF);
        tick();
        tx_word_load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("tx_stall_byte", 64'({tx_byte_a, tx_byte_b}), 64'(16'hEFDE));
            check("tx_stall_busy", 64'({tx_busy_a, tx_byte_valid_a}), 64'(2'b11));
            tick();
        end
        tx_byte_ready = 1'b1;
        tick();
        tx_word = 32'h12345678;
        tx_word_load = 1'b1;
        tick();
        tx_word_load = 1'b0;
        tx_word = '0;
        wait_done("tx_done_first");

        // Reload on the tx_done cycle.
        check("tx_idle_on_done", 64'(tx_busy_a), 64'd0);
        tx_word = 32'hCAFEF00D;
        tx_word_load = 1'b1;
        push_tx(32'hCAFEF00D);
        tick();
        tx_word_load = 1'b0;
        check("tx_busy_after_reload", 64'({tx_busy_a, tx_busy_b}), 64'(2'b11));
        wait_done("tx_done_second");
        tx_byte_ready = 1'b0;
        tick();
        check("tx_queue_drained", 64'(txq_a.size() + txq_b.size()), 64'd0);
        check("tx_done_count", 64'(n_done_seen), 64'd2);

        // Reset in the middle of an RX word and a TX word.
        done0 = n_done_seen;
        rx_byte = 8'hAA; rx_byte_valid = 1'b1;
        tick();
        rx_byte = 8'hBB;
        tick();
        rx_byte_valid = 1'b0;
        tx_word = 32'h01020304;
        tx_word_load = 1'b1;
        tick();
        tx_word_load = 1'b0;
        check("pre_reset_busy", 64'(tx_busy_a), 64'd1);
        #2 n_rst = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        txq_a.delete();
        txq_b.delete();
        tick();
        tx_byte_ready = 1'b1;
        run_rx(0);
        tx_byte_ready = 1'b0;
        check("no_done_after_reset", 64'(n_done_seen), 64'(done0));
        check("tx_idle_after_reset", 64'(tx_busy_a), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL global_timeout: got no finish, expected end before 200000");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
